key_emulator: RTL and testbench



---
 rtl/key_emulator.sv | 130 +++++++++++++
 tb/tb_key_emulator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_emulator.sv
// key_emulator: synthetic active-low push-button line.
// One accepted start yields bounce-in, hold, bounce-out and a released gap.
module key_emulator #(
  parameter int CNT_W         = 16,
  parameter int HOLD_CYCLES   = 16,
  parameter int BOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] hold_len,
  output logic             key_n,
  output logic             busy,
  output logic             done,
  output logic [7:0]       press_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HOLD,
    BOUNCE_OUT,
    GAP
  } state_t;

  localparam logic BOUNCE_EN = (BOUNCE_CYCLES > 0);
  localparam logic GAP_EN    = (GAP_CYCLES > 0);

  localparam logic [CNT_W-1:0] B_LAST =
    CNT_W'(BOUNCE_EN ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] G_LAST =
    CNT_W'(GAP_EN ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] H_DEF =
    CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  state_t           nstate;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ncnt;
  logic [CNT_W-1:0] h_last;
  logic             accept;
  logic             finish;

  // Line level for a given phase and its counter LSB.
  function automatic logic key_of(state_t s, logic c0);
    logic k;
    k = 1'b1;
    unique case (s)
      BOUNCE_IN:  k = c0;
      HOLD:       k = 1'b0;
      BOUNCE_OUT: k = ~c0;
      default:    k = 1'b1;
    endcase
    return k;
  endfunction

  assign accept = (state == IDLE) && start;
  assign finish = (state != IDLE) && (nstate == IDLE);

  always_comb begin
    nstate = state;
    ncnt   = cnt + CNT_W'(1);
    unique case (state)
      IDLE: begin
        ncnt = '0;
        if (start) begin
          if (BOUNCE_EN) nstate = BOUNCE_IN;
          else           nstate = HOLD;
        end
      end
      BOUNCE_IN: begin
        if (cnt == B_LAST) begin
          nstate = HOLD;
          ncnt   = '0;
        end
      end
      HOLD: begin
        if (cnt == h_last) begin
          ncnt = '0;
          if (BOUNCE_EN)   nstate = BOUNCE_OUT;
          else if (GAP_EN) nstate = GAP;
          else             nstate = IDLE;
        end
      end
      BOUNCE_OUT: begin
        if (cnt == B_LAST) begin
          ncnt = '0;
          if (GAP_EN) nstate = GAP;
          else        nstate = IDLE;
        end
      end
      GAP: begin
        if (cnt == G_LAST) begin
          nstate = IDLE;
          ncnt   = '0;
        end
      end
      default: begin
        nstate = IDLE;
        ncnt   = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      h_last    <= H_DEF;
      key_n     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      press_cnt <= 8'd0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      if (accept) begin
        if (hold_len == '0) h_last <= H_DEF;
        else                h_last <= hold_len - CNT_W'(1);
      end
      key_n <= key_of(nstate, ncnt[0]);
      busy  <= (nstate != IDLE);
      done  <= finish;
      if (finish) press_cnt <= press_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_key_emulator.sv
// tb_key_emulator: scoreboard bench for key_emulator.
// Two instances: default timing, and no-bounce/no-gap.
module tb_key_emulator;

  typedef struct {
    logic [63:0] wave;
    int          len;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1;
  logic        start_a = 1'b0;
  logic [15:0] hold_a = 16'd0;
  logic        key_a, busy_a, done_a;
  logic [7:0]  pcnt_a;

  logic        rst_b = 1'b1;
  logic        start_b = 1'b0;
  logic [15:0] hold_b = 16'd0;
  logic        key_b, busy_b, done_b;
  logic [7:0]  pcnt_b;

  int tests = 0;
  int fails = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  logic [63:0] tr_a = '0;
  logic [63:0] tr_b = '0;
  int          len_a = 0;
  int          len_b = 0;
  int          dn_b = 0;

  always #5 clk = ~clk;

  key_emulator #(
    .CNT_W(16), .HOLD_CYCLES(16),
    .BOUNCE_CYCLES(4), .GAP_CYCLES(8)
  ) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a),
    .hold_len(hold_a), .key_n(key_a), .busy(busy_a),
    .done(done_a), .press_cnt(pcnt_a)
  );

  key_emulator #(
    .CNT_W(16), .HOLD_CYCLES(16),
    .BOUNCE_CYCLES(0), .GAP_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b),
    .hold_len(hold_b), .key_n(key_b), .busy(busy_b),
    .done(done_b), .press_cnt(pcnt_b)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(logic [63:0] w, int l, logic [7:0] c);
    exp_t e;
    e.wave = w;
    e.len  = l;
    e.cnt  = c;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input bit sel_b, input int max);
    int n;
    n = 0;
    while ((sel_b ? q_b.size() : q_a.size()) > 0 && n < max) begin
      @(posedge clk);
      n++;
    end
    #1;
    if ((sel_b ? q_b.size() : q_a.size()) > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout_%s: got %0d pending expected 0",
               sel_b ? "b" : "a",
               sel_b ? q_b.size() : q_a.size());
      if (sel_b) q_b.delete();
      else       q_a.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_a) begin
      tr_a  = '0;
      len_a = 0;
    end else begin
      if (busy_a) begin
        tr_a = {tr_a[62:0], key_a};
        len_a++;
      end else begin
        chk("idle_key_a", 64'(key_a), 64'd1);
      end
      if (done_a) begin
        if (q_a.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_done_a: got done=1 expected 0");
        end else begin
          e = q_a.pop_front();
          chk("busy_len_a", 64'(len_a), 64'(e.len));
          chk("wave_a", tr_a, e.wave);
          chk("press_cnt_a", 64'(pcnt_a), 64'(e.cnt));
        end
        tr_a  = '0;
        len_a = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_b) begin
      tr_b  = '0;
      len_b = 0;
    end else begin
      if (busy_b) begin
        tr_b = {tr_b[62:0], key_b};
        len_b++;
      end else begin
        chk("idle_key_b", 64'(key_b), 64'd1);
      end
      if (done_b) begin
        dn_b++;
        if (q_b.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_done_b: got done=1 expected 0");
        end else begin
          e = q_b.pop_front();
          chk("busy_len_b", 64'(len_b), 64'(e.len));
          chk("wave_b", tr_b, e.wave);
          chk("press_cnt_b", 64'(pcnt_b), 64'(e.cnt));
        end
        tr_b  = '0;
        len_b = 0;
      end
    end
  end

  // 0101, 16 x 0, 1010, 8 x 1
  localparam logic [63:0] DEF_WAVE = 64'h5000_0AFF;

  initial begin
    repeat (3) tick();
    chk("rst_key_a", 64'(key_a), 64'd1);
    chk("rst_busy_a", 64'(busy_a), 64'd0);
    chk("rst_done_a", 64'(done_a), 64'd0);
    chk("rst_cnt_a", 64'(pcnt_a), 64'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();

    // rst and start together: rst wins
    rst_a = 1'b1;
    start_a = 1'b1;
    tick();
    chk("rs_busy_a", 64'(busy_a), 64'd0);
    chk("rs_key_a", 64'(key_a), 64'd1);
    rst_a = 1'b0;
    start_a = 1'b0;
    tick();
    chk("rs_busy2_a", 64'(busy_a), 64'd0);
    chk("rs_key2_a", 64'(key_a), 64'd1);

    // abort on 10th hold cycle
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (13) tick();
    chk("hold_key_a", 64'(key_a), 64'd0);
    chk("hold_busy_a", 64'(busy_a), 64'd1);
    rst_a = 1'b1;
    tick();
    chk("abort_key_a", 64'(key_a), 64'd1);
    chk("abort_busy_a", 64'(busy_a), 64'd0);
    chk("abort_done_a", 64'(done_a), 64'd0);
    chk("abort_cnt_a", 64'(pcnt_a), 64'd0);
    tick();
    rst_a = 1'b0;
    repeat (3) tick();
    chk("abort_cnt2_a", 64'(pcnt_a), 64'd0);

    // single default press
    q_a.push_back(mk(DEF_WAVE, 32, 8'd1));
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    drain(1'b0, 40);
    chk("single_cnt_a", 64'(pcnt_a), 64'd1);

    // start held high: three presses, 33 cycles apart
    q_a.push_back(mk(DEF_WAVE, 32, 8'd2));
    q_a.push_back(mk(DEF_WAVE, 32, 8'd3));
    q_a.push_back(mk(DEF_WAVE, 32, 8'd4));
    start_a = 1'b1;
    repeat (67) @(posedge clk);
    #1;
    start_a = 1'b0;
    drain(1'b0, 40);
    chk("b2b_cnt_a", 64'(pcnt_a), 64'd4);
    repeat (3) tick();
    chk("b2b_idle_a", 64'(busy_a), 64'd0);

    // 256 minimal presses, start held high
    hold_b = 16'd1;
    for (int i = 1; i <= 256; i++)
      q_b.push_back(mk(64'd0, 1, 8'(i)));
    start_b = 1'b1;
    repeat (511) @(posedge clk);
    #1;
    start_b = 1'b0;
    drain(1'b1, 10);
    chk("wrap_cnt_b", 64'(pcnt_b), 64'd0);
    chk("wrap_dones_b", 64'(dn_b), 64'd256);

    // hold_len=3, no bounce, no gap
    hold_b = 16'd3;
    q_b.push_back(mk(64'd0, 3, 8'd1));
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("h3_key_b", 64'(key_b), 64'd0);
    drain(1'b1, 10);
    chk("h3_cnt_b", 64'(pcnt_b), 64'd1);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
